// File: rtl/router_pkg.sv
// Shared definitions for the router input stage: flit types, port indices
// and flit field positions.
package router_pkg;

    localparam int TYPE_W     = 2;
    localparam int PORT_COUNT = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_S = 2;
    localparam int PORT_E = 3;
    localparam int PORT_W = 4;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } ru_state_e;

    // Field MSB positions measured from a flit of width dw.
    function automatic int type_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int dest_x_msb(input int dw);
        return dw - 1 - TYPE_W;
    endfunction

    function automatic int dest_y_msb(input int dw, input int cw);
        return dw - 1 - TYPE_W - cw;
    endfunction

endpackage

// File: rtl/router_input_unit_xy.sv
// Combinational XY dimension-order route: X is resolved before Y.
// Output is a one-hot request over the five router ports.
module xy_route_compute
    import router_pkg::*;
#(
    parameter int COORD_WIDTH = 2,
    parameter int CUR_X       = 0,
    parameter int CUR_Y       = 0
) (
    input  logic [COORD_WIDTH-1:0] dest_x,
    input  logic [COORD_WIDTH-1:0] dest_y,
    output logic [PORT_COUNT-1:0]  port
);

    localparam logic [COORD_WIDTH-1:0] CX = COORD_WIDTH'(CUR_X);
    localparam logic [COORD_WIDTH-1:0] CY = COORD_WIDTH'(CUR_Y);

    always_comb begin
        port = '0;
        if (dest_x > CX) begin
            port[PORT_E] = 1'b1;
        end else if (dest_x < CX) begin
            port[PORT_W] = 1'b1;
        end else if (dest_y > CY) begin
            port[PORT_N] = 1'b1;
        end else if (dest_y < CY) begin
            port[PORT_S] = 1'b1;
        end else begin
            port[PORT_L] = 1'b1;
        end
    end

endmodule

// File: rtl/router_input_unit.sv
// Input-port consumer: pops flits, routes each packet at its head and
// forwards flits through a one-entry valid/ready output register.
module router_input_unit
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 2,
    parameter int CUR_X       = 0,
    parameter int CUR_Y       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PORT_COUNT-1:0] out_port,
    output logic                  pkt_active,
    output logic                  err,
    output logic [15:0]           pkt_count
);

    localparam int T_MSB = type_msb(DATA_WIDTH);
    localparam int X_MSB = dest_x_msb(DATA_WIDTH);
    localparam int Y_MSB = dest_y_msb(DATA_WIDTH, COORD_WIDTH);

    ru_state_e             state;
    logic [PORT_COUNT-1:0] route_reg;
    logic [PORT_COUNT-1:0] calc_port;
    flit_type_e            ftype;
    logic                  pop;
    logic                  load;
    logic                  is_pkt_start;

    assign ftype = flit_type_e'(fifo_dout[T_MSB -: TYPE_W]);

    xy_route_compute #(
        .COORD_WIDTH (COORD_WIDTH),
        .CUR_X       (CUR_X),
        .CUR_Y       (CUR_Y)
    ) u_route (
        .dest_x (fifo_dout[X_MSB -: COORD_WIDTH]),
        .dest_y (fifo_dout[Y_MSB -: COORD_WIDTH]),
        .port   (calc_port)
    );

    // Rejected flits are still popped so a bad stream cannot wedge the FIFO.
    assign pop        = ~rst & ~fifo_empty & (~out_valid | out_ready);
    assign fifo_rd_en = pop;
    assign pkt_active = (state == S_ACTIVE);

    always_comb begin
        is_pkt_start = 1'b0;
        unique case (1'b1)
            ftype == FLIT_HEAD:   is_pkt_start = 1'b1;
            ftype == FLIT_SINGLE: is_pkt_start = 1'b1;
            ftype == FLIT_BODY:   is_pkt_start = 1'b0;
            ftype == FLIT_TAIL:   is_pkt_start = 1'b0;
        endcase
    end

    always_comb begin
        load = 1'b0;
        if (pop) begin
            unique case (state)
                S_IDLE:   load = is_pkt_start;
                S_ACTIVE: load = ~is_pkt_start;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            route_reg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            err       <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (pop && !load) begin
                err <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= fifo_dout;
                out_port  <= (state == S_IDLE) ? calc_port : route_reg;
                if (is_pkt_start) begin
                    pkt_count <= pkt_count + 16'd1;
                end
                unique case (ftype)
                    FLIT_HEAD: begin
                        route_reg <= calc_port;
                        state     <= S_ACTIVE;
                    end
                    FLIT_TAIL: state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Randomised bench for router_input_unit: a queue-based FIFO feeds the DUT
// and a packet-level scoreboard predicts every forwarded flit.
module tb_router_input_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_port;
    logic        pkt_active;
    logic        err;
    logic [15:0] pkt_count;

    router_input_unit #(
        .DATA_WIDTH  (32),
        .COORD_WIDTH (2),
        .CUR_X       (0),
        .CUR_Y       (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_port   (out_port),
        .pkt_active (pkt_active),
        .err        (err),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  port;
    } exp_t;

    logic [31:0] src[$];
    exp_t        exp_q[$];
    bit          m_active;
    bit          m_err;
    logic [15:0] m_count;
    logic [4:0]  m_route;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Router at (0,0): X first, then Y.
    function automatic logic [4:0] xy(input int dx, input int dy);
        if (dx > 0) return 5'b01000;
        if (dx < 0) return 5'b10000;
        if (dy > 0) return 5'b00010;
        if (dy < 0) return 5'b00100;
        return 5'b00001;
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] t, input int dx,
                                       input int dy);
        logic [25:0] pay;
        pay = 26'($urandom);
        return {t, 2'(dx), 2'(dy), pay};
    endfunction

    task automatic push_pkt(input int dx, input int dy, input int nbody);
        src.push_back(mk(2'b01, dx, dy));
        for (int i = 0; i < nbody; i++)
            src.push_back(mk(2'b00, $urandom_range(0, 3), $urandom_range(0, 3)));
        src.push_back(mk(2'b10, $urandom_range(0, 3), $urandom_range(0, 3)));
    endtask

    task automatic model_pop(input logic [31:0] f);
        logic [1:0] t;
        exp_t e;
        t = f[31:30];
        e.data = f;
        if (!m_active) begin
            if (t == 2'b01 || t == 2'b11) begin
                e.port = xy(int'(f[29:28]), int'(f[27:26]));
                exp_q.push_back(e);
                m_count = m_count + 16'd1;
                if (t == 2'b01) begin
                    m_active = 1'b1;
                    m_route  = e.port;
                end
            end else begin
                m_err = 1'b1;
            end
        end else begin
            if (t == 2'b00 || t == 2'b10) begin
                e.port = m_route;
                exp_q.push_back(e);
                if (t == 2'b10) m_active = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // rmode: 0 random ready, 1 ready high, 2 ready low
    task automatic step(input int rmode);
        bit ov, rdy, want_pop;
        @(negedge clk);
        ov = (exp_q.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("pkt_active", 32'(pkt_active), 32'(m_active));
        chk("err", 32'(err), 32'(m_err));
        chk("pkt_count", 32'(pkt_count), 32'(m_count));
        if (ov) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_port", 32'(out_port), 32'(exp_q[0].port));
        end
        rst = 1'b0;
        rdy = (rmode == 1) ? 1'b1 :
              (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        out_ready  = rdy;
        fifo_empty = (src.size() == 0);
        fifo_dout  = fifo_empty ? $urandom : src[0];
        #1;
        want_pop = !fifo_empty && (!ov || rdy);
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(want_pop));
        if (ov && rdy) void'(exp_q.pop_front());
        if (want_pop) model_pop(src.pop_front());
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_data", out_data, 32'd0);
                chk("rst_port", 32'(out_port), 32'd0);
                chk("rst_active", 32'(pkt_active), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_count", 32'(pkt_count), 32'd0);
            end
            rst        = 1'b1;
            fifo_empty = 1'b0;
            fifo_dout  = $urandom;
            out_ready  = 1'(($urandom));
            #1;
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        exp_q.delete();
        m_active = 1'b0;
        m_err    = 1'b0;
        m_count  = '0;
        m_route  = '0;
    endtask

    task automatic run(input int n, input int rmode);
        for (int i = 0; i < n; i++) step(rmode);
    endtask

    initial begin
        do_reset(2);
        run(3, 1);

        // east packet, back to back
        push_pkt(2, 1, 1);
        run(6, 1);

        // north packet with a 4-cycle stall mid-packet
        push_pkt(0, 3, 3);
        run(2, 1);
        run(4, 2);
        run(8, 1);

        // single flit to local
        src.push_back(mk(2'b11, 0, 0));
        run(3, 1);

        // body while idle, then head while active
        src.push_back(mk(2'b00, 1, 1));
        run(3, 1);
        src.push_back(mk(2'b01, 0, 2));
        src.push_back(mk(2'b01, 3, 0));
        src.push_back(mk(2'b10, 0, 0));
        run(6, 1);

        // reset mid-packet, then a stale tail
        do_reset(2);
        src.push_back(mk(2'b01, 1, 0));
        run(1, 1);
        do_reset(1);
        src.push_back(mk(2'b10, 0, 0));
        run(4, 1);

        // randomised traffic
        do_reset(2);
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                do_reset(1);
            end else if (sel < 18) begin
                src.push_back(mk(2'($urandom), $urandom_range(0, 3),
                                 $urandom_range(0, 3)));
            end else if (sel < 35) begin
                src.push_back(mk(2'b11, $urandom_range(0, 3),
                                 $urandom_range(0, 3)));
            end else begin
                push_pkt($urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            end
            run($urandom_range(0, 6), 0);
        end

        for (int i = 0; i < 400; i++) begin
            if (src.size() == 0 && exp_q.size() == 0) break;
            step(1);
        end
        chk("drain", 32'(src.size() + exp_q.size()), 32'd0);
        run(2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
